// File: rtl/hilo_mul_if.sv
// Handshake and data bus between the pipeline and the HI/LO multiplier unit.
interface hilo_mul_if #(
    parameter int unsigned WIDTH = 32
);
    logic             MULTU;
    logic             MADDU;
    logic [1:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] dataOut;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side: issues strobes and operands, reads results.
    modport master (
        output MULTU, MADDU, sel, a, b,
        input  dataOut, busy, done, hi, lo
    );

    // Multiplier side.
    modport slave (
        input  MULTU, MADDU, sel, a, b,
        output dataOut, busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_mul_unit.sv
// Multi-cycle unsigned shift-add multiplier (MULTU / MADDU) with HI/LO registers
// and a combinational MFHI/MFLO read port.
module hilo_mul_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    hilo_mul_if.slave    bus
);
    typedef enum logic [1:0] {StIdle, StRun, StWb, StDone} state_e;

    state_e               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic [2*WIDTH-1:0]   product;
    logic [CNT_W-1:0]     counter;
    logic                 acc_mode;

    logic                 start;
    logic [WIDTH:0]       add_sum;
    logic [2*WIDTH-1:0]   shifted;

    // One shift-add step: conditionally add the multiplicand into the upper half
    // (keeping the carry), then shift {carry, product} right by one.
    always_comb begin
        start   = bus.MULTU | bus.MADDU;
        add_sum = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        if (product[0]) begin
            shifted = {add_sum, product[WIDTH-1:1]};
        end else begin
            shifted = {1'b0, product[2*WIDTH-1:1]};
        end
    end

    // Control FSM and datapath registers; starts are only accepted in IDLE or DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            mcand    <= '0;
            product  <= '0;
            counter  <= '0;
            acc_mode <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        acc_mode <= bus.MADDU;
                        mcand    <= bus.a;
                        // Multiplier lives in the low half and is consumed as it shifts out.
                        product  <= {{WIDTH{1'b0}}, bus.b};
                        counter  <= '0;
                        state    <= StRun;
                    end else begin
                        state    <= StIdle;
                    end
                end
                StRun: begin
                    product <= shifted;
                    counter <= counter + CNT_W'(1);
                    if (counter == CNT_W'(WIDTH - 1)) begin
                        state <= StWb;
                    end
                end
                StWb: begin
                    if (acc_mode) begin
                        {hi_r, lo_r} <= {hi_r, lo_r} + product;
                    end else begin
                        {hi_r, lo_r} <= product;
                    end
                    state <= StDone;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Status flags decode straight from the state register; read port is combinational.
    always_comb begin
        bus.busy = (state == StRun) || (state == StWb);
        bus.done = (state == StDone);
        bus.hi   = hi_r;
        bus.lo   = lo_r;
        case (bus.sel)
            2'b01:   bus.dataOut = hi_r;
            2'b10:   bus.dataOut = lo_r;
            default: bus.dataOut = '0;
        endcase
    end
endmodule

// File: tb/tb_hilo_mul_unit.sv
// Randomised bench for hilo_mul_unit against a transaction-level reference model.
module tb_hilo_mul_unit;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    bit   chk_en;

    hilo_mul_if #(.WIDTH(32)) bus ();

    hilo_mul_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an accepted op completes 33 edges later with a*b
    // (or HI:LO + a*b), modulo 2^64; starts while an op is pending are dropped.
    logic [63:0] m_hilo;
    logic [63:0] m_prod;
    logic        m_acc;
    logic        m_done;
    int          m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hilo <= '0;
            m_prod <= '0;
            m_acc  <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) m_hilo <= m_acc ? m_hilo + m_prod : m_prod;
        end else begin
            m_done <= 1'b0;
            if (bus.MULTU || bus.MADDU) begin
                m_acc  <= bus.MADDU;
                m_prod <= {32'b0, bus.a} * {32'b0, bus.b};
                m_left <= 33;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] exp_do;
            case (bus.sel)
                2'b01:   exp_do = m_hilo[63:32];
                2'b10:   exp_do = m_hilo[31:0];
                default: exp_do = '0;
            endcase
            check("busy", 64'(bus.busy), 64'(m_left > 0));
            check("done", 64'(bus.done), 64'(m_done));
            check("hi", 64'(bus.hi), 64'(m_hilo[63:32]));
            check("lo", 64'(bus.lo), 64'(m_hilo[31:0]));
            check("dataOut", 64'(bus.dataOut), 64'(exp_do));
        end
    end

    // Drive a start strobe; sync=0 drives in the current cycle (e.g. the DONE cycle).
    task automatic start_op(input bit mu, input bit md, input logic [31:0] aa,
                            input logic [31:0] bb, input bit sync);
        if (sync) begin
            @(negedge clk);
            #1;
        end
        bus.MULTU = mu;
        bus.MADDU = md;
        bus.a     = aa;
        bus.b     = bb;
    endtask

    // Wait for done, counting busy cycles; optionally pulses a stray start at pulse_at.
    task automatic wait_done(input int pulse_at, output int done_at, output int busy_cnt);
        done_at  = 0;
        busy_cnt = 0;
        for (int n = 1; n <= 100; n++) begin
            logic d;
            @(negedge clk);
            #1;
            d = bus.done;
            busy_cnt += int'(bus.busy);
            if (n == 1 || n == pulse_at + 1) begin
                bus.MULTU = 1'b0;
                bus.MADDU = 1'b0;
                bus.a     = $urandom;
                bus.b     = $urandom;
            end
            if (pulse_at >= 2 && n == pulse_at) begin
                bus.MULTU = 1'($urandom);
                bus.MADDU = 1'b1;
                bus.a     = 32'd100;
                bus.b     = 32'd100;
            end
            bus.sel = 2'($urandom);
            if (d) begin
                done_at = n;
                break;
            end
        end
        if (done_at == 0) check("done timeout", 64'(0), 64'(1));
    endtask

    task automatic run(input bit mu, input bit md, input logic [31:0] aa, input logic [31:0] bb,
                       input bit sync, input int pulse_at, output int done_at,
                       output int busy_cnt);
        start_op(mu, md, aa, bb, sync);
        wait_done(pulse_at, done_at, busy_cnt);
    endtask

    task automatic read_sel(input logic [1:0] s, input string name, input logic [31:0] exp);
        bus.sel = s;
        #1;
        check(name, 64'(bus.dataOut), 64'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int da;
        int bc;
        errors    = 0;
        checks    = 0;
        chk_en    = 1'b0;
        rst       = 1'b1;
        bus.MULTU = 1'b0;
        bus.MADDU = 1'b0;
        bus.sel   = 2'b01;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("reset hi", 64'(bus.hi), 64'h0);
        check("reset lo", 64'(bus.lo), 64'h0);
        check("reset busy", 64'(bus.busy), 64'h0);
        check("reset done", 64'(bus.done), 64'h0);
        check("reset dataOut", 64'(bus.dataOut), 64'h0);
        chk_en = 1'b1;

        // 3*5, latency and read port
        run(1'b1, 1'b0, 32'd3, 32'd5, 1'b1, 0, da, bc);
        check("3x5 done latency", 64'(da), 64'd34);
        check("3x5 busy cycles", 64'(bc), 64'd33);
        check("3x5 hi", 64'(bus.hi), 64'h0);
        check("3x5 lo", 64'(bus.lo), 64'hF);
        read_sel(2'b10, "3x5 sel=LO", 32'hF);
        read_sel(2'b01, "3x5 sel=HI", 32'h0);

        // All-ones squared
        run(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, da, bc);
        check("max busy cycles", 64'(bc), 64'd33);
        check("max hi", 64'(bus.hi), 64'hFFFF_FFFE);
        check("max lo", 64'(bus.lo), 64'h1);

        // Chain up to all-ones, then wrap with MADDU 1*1
        run(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1, 0, da, bc);
        check("ones hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("ones lo", 64'(bus.lo), 64'hFFFF_FFFF);
        run(1'b0, 1'b1, 32'd1, 32'd1, 1'b1, 0, da, bc);
        check("wrap hi", 64'(bus.hi), 64'h0);
        check("wrap lo", 64'(bus.lo), 64'h0);

        // 0x10 + 2*3
        run(1'b1, 1'b0, 32'd4, 32'd4, 1'b1, 0, da, bc);
        run(1'b0, 1'b1, 32'd2, 32'd3, 1'b1, 0, da, bc);
        check("madd lo", 64'(bus.lo), 64'h16);

        // Stray start mid-run is ignored; start in DONE cycle chains
        run(1'b1, 1'b0, 32'd7, 32'd6, 1'b1, 10, da, bc);
        check("ignored start lo", 64'(bus.lo), 64'd42);
        check("ignored start latency", 64'(da), 64'd34);
        run(1'b0, 1'b1, 32'd3, 32'd3, 1'b0, 0, da, bc);
        check("chain latency", 64'(da), 64'd34);
        check("chain lo", 64'(bus.lo), 64'd51);

        // Reset mid-operation
        start_op(1'b1, 1'b0, 32'd9, 32'd9, 1'b1);
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            #1;
            bus.MULTU = 1'b0;
        end
        #1;
        rst = 1'b1;
        #1;
        check("abort busy", 64'(bus.busy), 64'h0);
        check("abort done", 64'(bus.done), 64'h0);
        check("abort hi", 64'(bus.hi), 64'h0);
        check("abort lo", 64'(bus.lo), 64'h0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run(1'b1, 1'b0, 32'd2, 32'd2, 1'b1, 0, da, bc);
        check("post-reset lo", 64'(bus.lo), 64'd4);

        // Unused selects read zero; MADDU wins over MULTU
        run(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, da, bc);
        read_sel(2'b11, "sel=11", 32'h0);
        read_sel(2'b00, "sel=00", 32'h0);
        run(1'b1, 1'b0, 32'd1, 32'd1, 1'b1, 0, da, bc);
        run(1'b1, 1'b1, 32'd2, 32'd2, 1'b1, 0, da, bc);
        check("priority hi", 64'(bus.hi), 64'h0);
        check("priority lo", 64'(bus.lo), 64'd5);

        // Random operations, stray starts and back-to-back chains
        for (int i = 0; i < 40; i++) begin
            bit          mu;
            bit          md;
            logic [31:0] ra;
            logic [31:0] rb;
            int          pa;
            md = 1'($urandom);
            mu = md ? 1'($urandom) : 1'b1;
            ra = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            pa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 31)) : 0;
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(0, 3)) @(negedge clk);
            run(mu, md, ra, rb, 1'($urandom), pa, da, bc);
            check("random latency", 64'(da), 64'd34);
        end

        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
